// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic array control path.
package systolic_pkg;

   localparam int unsigned CntrW = 16;

   localparam logic [15:2] AdrStart  = 14'h3FF8;
   localparam logic [15:2] AdrMax    = 14'h3FF9;
   localparam logic [15:2] AdrRun    = 14'h3FFA;
   localparam logic [15:2] AdrStatus = 14'h3FFB;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StDone
   } sys_state_e;

endpackage

// File: rtl/systolic_ctrl_regs_seq_cntr.sv
// Nested step/round counter with wrap and last flag; shared with the buffer address generators.
module sys_seq_cntr
   import systolic_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [CntrW-1:0] step_max_i,
   input  logic [CntrW-1:0] round_max_i,
   output logic [CntrW-1:0] step_o,
   output logic [CntrW-1:0] round_o,
   output logic             last_o
);

   logic [CntrW-1:0] step_q;
   logic [CntrW-1:0] round_q;
   logic             step_wrap;

   // Equality is tested before incrementing, so all-ones limits never overflow.
   assign step_wrap = (step_q == step_max_i);

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         step_q  <= '0;
         round_q <= '0;
      end else if (en_i) begin
         if (step_wrap) begin
            step_q <= '0;
            if (round_q != round_max_i) begin
               round_q <= round_q + 1'b1;
            end
         end else begin
            step_q <= step_q + 1'b1;
         end
      end
   end

   assign step_o  = step_q;
   assign round_o = round_q;
   assign last_o  = step_wrap && (round_q == round_max_i);

endmodule

// File: rtl/systolic_ctrl_regs.sv
// Control/status register responder that sequences the systolic array through its rounds.
module systolic_ctrl_regs
   import systolic_pkg::*;
#(
   parameter logic [15:2] ADR_START    = AdrStart,
   parameter logic [15:2] ADR_MAX      = AdrMax,
   parameter logic [15:2] ADR_RUN      = AdrRun,
   parameter logic [15:2] ADR_STATUS   = AdrStatus,
   parameter int unsigned DRAIN_CYCLES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dma_io_we,
   input  logic [15:2] dma_io_wadr,
   input  logic [15:0] dma_io_wdata,
   input  logic [15:2] dma_io_radr,
   input  logic [15:0] dma_io_rdata_in,
   output logic [15:0] dma_io_rdata,
   output logic        sys_run,
   output logic [15:0] sys_step,
   output logic [15:0] sys_round,
   output logic        sys_round_start,
   output logic        sys_done
);

   localparam logic [CntrW-1:0] DrainLast = CntrW'(DRAIN_CYCLES - 1);

   sys_state_e       state_q;
   logic [CntrW-1:0] max_q;
   logic [CntrW-1:0] run_q;
   logic [CntrW-1:0] drain_q;
   logic             done_sticky_q;

   logic             idle;
   logic             busy;
   logic             wr_max;
   logic             wr_run;
   logic             start_acc;
   logic             cnt_last;
   logic [CntrW-1:0] step;
   logic [CntrW-1:0] round;

   assign idle      = (state_q == StIdle);
   assign busy      = !idle;
   assign wr_max    = dma_io_we && (dma_io_wadr == ADR_MAX) && idle;
   assign wr_run    = dma_io_we && (dma_io_wadr == ADR_RUN) && idle;
   assign start_acc = dma_io_we && (dma_io_wadr == ADR_START) && dma_io_wdata[0] && idle;

   sys_seq_cntr u_seq_cntr (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (start_acc),
      .en_i        (state_q == StRun),
      .step_max_i  (max_q),
      .round_max_i (run_q),
      .step_o      (step),
      .round_o     (round),
      .last_o      (cnt_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         max_q         <= '0;
         run_q         <= '0;
         drain_q       <= '0;
         done_sticky_q <= 1'b0;
      end else begin
         if (wr_max) max_q <= dma_io_wdata;
         if (wr_run) run_q <= dma_io_wdata;
         case (state_q)
            StIdle: begin
               if (start_acc) begin
                  state_q       <= StRun;
                  done_sticky_q <= 1'b0;
               end
            end
            StRun: begin
               if (cnt_last) begin
                  state_q <= StDrain;
                  drain_q <= '0;
               end
            end
            StDrain: begin
               if (drain_q == DrainLast) state_q <= StDone;
               else                      drain_q <= drain_q + 1'b1;
            end
            StDone: begin
               done_sticky_q <= 1'b1;
               state_q       <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign sys_run         = (state_q == StRun);
   assign sys_step        = step;
   assign sys_round       = round;
   assign sys_round_start = sys_run && (step == '0);
   assign sys_done        = (state_q == StDone);

   always_comb begin
      dma_io_rdata = dma_io_rdata_in;
      if (dma_io_radr == ADR_START)       dma_io_rdata = {15'b0, busy};
      else if (dma_io_radr == ADR_MAX)    dma_io_rdata = max_q;
      else if (dma_io_radr == ADR_RUN)    dma_io_rdata = run_q;
      else if (dma_io_radr == ADR_STATUS) dma_io_rdata = {14'b0, done_sticky_q, busy};
   end

endmodule

// File: tb/tb_systolic_ctrl_regs.sv
// Scoreboard bench: stimulus pushes the expected step/round sequence, a monitor pops and checks.
module tb_systolic_ctrl_regs;

   localparam int unsigned D = 8;
   localparam logic [15:2] A_START  = 14'h3FF8;
   localparam logic [15:2] A_MAX    = 14'h3FF9;
   localparam logic [15:2] A_RUN    = 14'h3FFA;
   localparam logic [15:2] A_STATUS = 14'h3FFB;

   typedef struct packed {
      logic [15:0] step;
      logic [15:0] round;
   } run_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we = 1'b0;
   logic [15:2] wadr = '0;
   logic [15:0] wdata = '0;
   logic [15:2] radr = '0;
   logic [15:0] rdata_in = '0;
   logic [15:0] rdata;
   logic        sys_run;
   logic [15:0] sys_step;
   logic [15:0] sys_round;
   logic        sys_round_start;
   logic        sys_done;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int run_len = 0;
   int gap = 0;

   run_t exp_run_q[$];
   int   exp_done_q[$];
   run_t mon_e;
   int   mon_r;

   // Behavioural model of the register file
   logic [15:0] m_max = '0;
   logic [15:0] m_run = '0;
   logic        m_busy = 1'b0;
   logic        m_sticky = 1'b0;

   always #5 clk = ~clk;

   systolic_ctrl_regs #(
      .DRAIN_CYCLES (D)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .dma_io_we       (we),
      .dma_io_wadr     (wadr),
      .dma_io_wdata    (wdata),
      .dma_io_radr     (radr),
      .dma_io_rdata_in (rdata_in),
      .dma_io_rdata    (rdata),
      .sys_run         (sys_run),
      .sys_step        (sys_step),
      .sys_round       (sys_round),
      .sys_round_start (sys_round_start),
      .sys_done        (sys_done)
   );

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic logic [15:0] model_rd(input logic [15:2] a);
      if (a == A_START)  return {15'b0, m_busy};
      if (a == A_MAX)    return m_max;
      if (a == A_RUN)    return m_run;
      if (a == A_STATUS) return {14'b0, m_sticky, m_busy};
      return rdata_in;
   endfunction

   // Monitor: every RUN cycle consumes one expected (step, round); every done consumes a run length.
   always @(negedge clk) begin
      if (rst) begin
         run_len = 0;
         gap = 0;
      end else begin
         if (sys_run) begin
            run_len++;
            gap = 0;
            chk("run_queued", 32'(exp_run_q.size() > 0), 32'd1);
            if (exp_run_q.size() > 0) begin
               mon_e = exp_run_q.pop_front();
               chk("step", 32'(sys_step), 32'(mon_e.step));
               chk("round", 32'(sys_round), 32'(mon_e.round));
               chk("round_start", 32'(sys_round_start), 32'(mon_e.step == 16'd0));
            end
         end else begin
            chk("round_start_idle", 32'(sys_round_start), 32'd0);
            if (run_len > 0) gap++;
         end
         if (sys_done) begin
            chk("done_queued", 32'(exp_done_q.size() > 0), 32'd1);
            if (exp_done_q.size() > 0) begin
               mon_r = exp_done_q.pop_front();
               chk("run_cycles", 32'(run_len), 32'(mon_r));
               chk("drain_gap", 32'(gap), 32'(D + 1));
            end
            run_len = 0;
            gap = 0;
            done_cnt++;
         end
      end
   end

   task automatic wr(input logic [15:2] a, input logic [15:0] d);
      we = 1'b1;
      wadr = a;
      wdata = d;
      if (!m_busy) begin
         if (a == A_MAX) m_max = d;
         if (a == A_RUN) m_run = d;
         if (a == A_START && d[0]) begin
            m_busy = 1'b1;
            m_sticky = 1'b0;
            for (int r = 0; r <= int'(m_run); r++)
               for (int s = 0; s <= int'(m_max); s++)
                  exp_run_q.push_back('{step: 16'(s), round: 16'(r)});
            exp_done_q.push_back((int'(m_max) + 1) * (int'(m_run) + 1));
         end
      end
      @(posedge clk);
      #1;
      we = 1'b0;
   endtask

   task automatic rd(input logic [15:2] a, input string nm);
      radr = a;
      #1;
      chk(nm, 32'(rdata), 32'(model_rd(a)));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_run_q.delete();
      exp_done_q.delete();
      m_max = '0;
      m_run = '0;
      m_busy = 1'b0;
      m_sticky = 1'b0;
   endtask

   task automatic wait_done();
      int  c0;
      bit  ok;
      c0 = done_cnt;
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         if (done_cnt != c0) begin
            ok = 1'b1;
            break;
         end
      end
      #1;
      chk("done_seen", 32'(ok), 32'd1);
      if (ok) begin
         m_busy = 1'b0;
         m_sticky = 1'b1;
      end else begin
         do_reset();
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      chk("rst_run", 32'(sys_run), 32'd0);
      chk("rst_step", 32'(sys_step), 32'd0);
      chk("rst_round", 32'(sys_round), 32'd0);
      chk("rst_done", 32'(sys_done), 32'd0);
      rd(A_START, "rst_start");
      rd(A_MAX, "rst_max");
      rd(A_RUN, "rst_run_reg");
      rd(A_STATUS, "rst_status");
      rdata_in = 16'h1234;
      rd(14'h0010, "passthru");
      chk("passthru_const", 32'(rdata), 32'h1234);

      // 4x4 run with ignored writes while busy
      wr(A_MAX, 16'd3);
      wr(A_RUN, 16'd3);
      rd(A_MAX, "max_rb");
      wr(A_START, 16'hFFFF);
      rd(A_START, "start_busy");
      rd(A_STATUS, "status_busy");
      wr(A_MAX, 16'd7);
      wr(A_START, 16'd1);
      wait_done();
      rd(A_MAX, "max_kept");
      chk("max_kept_const", 32'(rdata), 32'd3);
      rd(A_STATUS, "status_after");
      chk("status_after_const", 32'(rdata), 32'h2);
      rd(A_START, "start_idle");

      // Single-step single-round run
      wr(A_MAX, 16'd0);
      wr(A_RUN, 16'd0);
      wr(A_START, 16'd1);
      rd(A_START, "start_min_busy");
      wait_done();
      rd(A_START, "start_min_idle");

      // START with bit0 clear does nothing; a real start clears done_sticky
      wr(A_START, 16'h0000);
      repeat (5) @(posedge clk);
      #1;
      rd(A_STATUS, "status_nostart");
      wr(A_START, 16'h0001);
      rd(A_STATUS, "status_cleared");
      wait_done();
      rd(A_STATUS, "status_set");

      // Randomized runs
      for (int it = 0; it < 8; it++) begin
         wr(A_MAX, 16'($urandom_range(0, 4)));
         wr(A_RUN, 16'($urandom_range(0, 3)));
         rd(A_RUN, "rnd_run_rb");
         rdata_in = 16'($urandom);
         rd(14'($urandom_range(0, 14'h3FF7)), "rnd_passthru");
         if ($urandom_range(0, 1) == 0) begin
            wr(A_START, 16'($urandom) & 16'hFFFE);
            wr(A_STATUS, 16'($urandom));
            rd(A_STATUS, "rnd_nostart");
         end
         wr(A_START, 16'($urandom) | 16'h0001);
         wr(($urandom_range(0, 1) == 0) ? A_MAX : A_RUN, 16'($urandom));
         rd(A_STATUS, "rnd_status_busy");
         wait_done();
         rd(A_MAX, "rnd_max_after");
         rd(A_STATUS, "rnd_status_done");
      end

      // Reset in round 2 of a 4x4 run
      wr(A_MAX, 16'd3);
      wr(A_RUN, 16'd3);
      wr(A_START, 16'd1);
      repeat (9) @(posedge clk);
      #1;
      chk("pre_reset_round", 32'(sys_round), 32'd2);
      do_reset();
      chk("mid_rst_run", 32'(sys_run), 32'd0);
      chk("mid_rst_step", 32'(sys_step), 32'd0);
      chk("mid_rst_round", 32'(sys_round), 32'd0);
      chk("mid_rst_rs", 32'(sys_round_start), 32'd0);
      chk("mid_rst_done", 32'(sys_done), 32'd0);
      rd(A_MAX, "mid_rst_max");
      rd(A_RUN, "mid_rst_runreg");
      rd(A_STATUS, "mid_rst_status");
      repeat (30) @(posedge clk);
      #1;

      chk("run_q_empty", 32'(exp_run_q.size()), 32'd0);
      chk("done_q_empty", 32'(exp_done_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/systolic_ctrl_regs.md
# systolic_ctrl_regs

Control/status register responder for the systolic array on the dma_io bus. Decodes start, step-limit and round-limit register writes, sequences the array through `run_cntr+1` rounds of `max_cntr+1` compute steps plus a pipeline drain, and answers register reads. Non-matching reads pass through from the upstream daisy chain. Sits between the dma_io bus and the systolic PE grid and buffer address generators.

## Interface
Parameters:
- ADR_START, 14'h3FF8, start/busy register word address
- ADR_MAX, 14'h3FF9, step-limit register (max_cntr)
- ADR_RUN, 14'h3FFA, round-limit register (run_cntr)
- ADR_STATUS, 14'h3FFB, read-only status register
- DRAIN_CYCLES, 8, pipeline flush cycles after the last step (≥1)

Ports:
- clk, in, 1, sole clock
- rst, in, 1, reset; synchronous, active-high
- dma_io_we, in, 1, write strobe, single-cycle
- dma_io_wadr, in, [15:2], write word address
- dma_io_wdata, in, 16, write data
- dma_io_radr, in, [15:2], read word address
- dma_io_rdata_in, in, 16, upstream read data (daisy chain)
- dma_io_rdata, out, 16, read data
- sys_run, out, 1, high during the RUN state
- sys_step, out, 16, step index within the round
- sys_round, out, 16, round index
- sys_round_start, out, 1, pulse on step 0 of every round
- sys_done, out, 1, one-cycle pulse at completion

## Operation
- Registers:
  - max_cntr (16b, rw, reset 0)
  - run_cntr (16b, rw, reset 0)
  - START reads {15'b0, busy}
  - STATUS reads {14'b0, done_sticky, busy}
- Writes to MAX/RUN while busy are ignored.
- START write with wdata[0]=1 while IDLE:
  - clears done_sticky
  - enters RUN next cycle with step=0, round=0
- START write with wdata[0]=0, any START write while busy, and STATUS writes have no effect.
- FSM IDLE → RUN → DRAIN → DONE → IDLE. busy=1 in RUN, DRAIN and DONE.
- RUN, each cycle:
  - if step==max_cntr: step←0; if round==run_cntr go to DRAIN, else round←round+1
  - otherwise step←step+1
- DRAIN: a drain counter runs from 0 to DRAIN_CYCLES-1, then the FSM goes to DONE.
- DONE: sys_done=1 for that cycle, done_sticky←1, then IDLE.
- Total busy time = (max+1)(run+1)+DRAIN_CYCLES+1 cycles.
- Counter behaviour:
  - max_cntr=0 gives one step per round.
  - max=run=16'hFFFF must complete without overflow; the comparison is equality before increment.
- sys_step and sys_round hold their last values in DRAIN, DONE and IDLE, until the next start.
- Read is combinational: if dma_io_radr matches one of the four addresses, local data is returned; otherwise dma_io_rdata_in.

## Timing
- Reset values: all outputs 0 (except dma_io_rdata = dma_io_rdata_in for non-local radr); FSM IDLE; registers 0; done_sticky 0.
- Register writes take effect on the clock edge where dma_io_we=1 and are visible on reads the next cycle.
- START accepted at edge T:
  - sys_run=1 and sys_round_start=1 from T+1
  - sys_step=0 at T+1
- Cycle T+k (k ≥ 1) of RUN presents step (k-1) mod (max+1).
- Last RUN cycle is followed by DRAIN_CYCLES DRAIN cycles, then the single DONE cycle.
- Reads of START/STATUS reflect busy combinationally from the FSM register; busy clears in the cycle after DONE.
- rst asserted mid-run: next edge forces IDLE and clears all counters, registers and outputs; there is no done pulse.

## Structure
- Shared package `systolic_pkg`:
  - the four address constants
  - FSM state enum (IDLE, RUN, DRAIN, DONE)
  - counter width localparam (16)
- Sub-module `sys_seq_cntr`: nested step/round counter with wrap and last-flag; it is reused by the buffer address generators.
- Register decode and read mux stay in the top module.

## Test plan
- Reset, then read all four addresses → 0,0,0,0; read 14'h0010 with dma_io_rdata_in=16'h1234 → 16'h1234.
- Write MAX=3, RUN=3, START=16'hFFFF → sys_run high for exactly 16 cycles; sys_step sequence 0,1,2,3 repeated 4 times; sys_round 0..3; four sys_round_start pulses; sys_done 9 cycles after sys_run falls; STATUS=16'h0002 afterwards.
- While busy, write MAX=7 and START=1 → MAX reads back 3, run length unchanged, single sys_done.
- MAX=0, RUN=0, start → 1 RUN cycle, DRAIN_CYCLES DRAIN cycles, done; START reads 1 during that window and 0 afterwards.
- START write with wdata=16'h0000 → no run; then start properly → done_sticky cleared at start, set at DONE.
- Assert rst during RUN at round 2 → next cycle all outputs 0, FSM IDLE, registers 0, no sys_done.
